// File: rtl/sha_pkg.sv
// Shared constants for the SHA-256 core sequencer: state encoding, core
// command opcodes and block/digest word counts.
package sha_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_READ  = 3'd4;
  localparam logic [2:0] ST_OUT   = 3'd5;

  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_START = 2'b11;

  localparam int BLK_WORDS = 16;
  localparam int DIG_WORDS = 8;

endpackage

// File: rtl/sha_sequencer.sv
// Streams 16-word blocks into a SHA-256 core, starts it, and returns the 8-word digest.
// Optional busy watchdog enabled by defining SHA_SEQ_TIMEOUT_EN.
module sha_sequencer
  import sha_pkg::*;
#(
  parameter int BUSY_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        blk_valid,
  input  logic [31:0] blk_word,
  input  logic        blk_first,
  output logic        blk_ready,
  output logic        dig_valid,
  output logic [31:0] dig_word,
  output logic        dig_last,
  input  logic        dig_ready,
  output logic [31:0] text_i,
  input  logic [31:0] text_o,
  output logic [2:0]  cmd_i,
  output logic        cmd_w_i,
  input  logic [3:0]  cmd_o,
  output logic        busy,
  output logic        error
);

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        first_q, first_d;
  logic [2:0]  idx_q, idx_d;
  logic [1:0]  rph_q, rph_d;
  logic        settle_q, settle_d;
  logic        rdy_en_q, rdy_en_d;
  logic [31:0] text_q, text_d;
  logic [2:0]  cmd_q, cmd_d;
  logic        cmd_w_q, cmd_w_d;
  logic [31:0] dig_word_q, dig_word_d;
  logic        accept;
  logic        unused_bits;

`ifdef SHA_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(BUSY_TIMEOUT + 1) + 1;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          error_q, error_d;
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign unused_bits = ^{cmd_o[2:0], BUSY_TIMEOUT};

  // blk_ready stays low for the first edge after reset release.
  assign blk_ready = rdy_en_q && (state_q == ST_IDLE || state_q == ST_LOAD);
  assign accept    = blk_valid && blk_ready;
  assign dig_valid = (state_q == ST_OUT);
  assign dig_last  = dig_valid && (idx_q == 3'(DIG_WORDS - 1));
  assign dig_word  = dig_word_q;
  assign text_i    = text_q;
  assign cmd_i     = cmd_q;
  assign cmd_w_i   = cmd_w_q;
  assign busy      = (state_q != ST_IDLE);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    first_d    = first_q;
    idx_d      = idx_q;
    rph_d      = rph_q;
    settle_d   = settle_q;
    rdy_en_d   = 1'b1;
    text_d     = text_q;
    cmd_d      = 3'b000;
    cmd_w_d    = 1'b0;
    dig_word_d = dig_word_q;
`ifdef SHA_SEQ_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
    error_d    = error_q;
`endif
    // All core commands are registered: they appear one cycle after the decision.
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          first_d = blk_first;
          cnt_d   = 4'd1;
          text_d  = blk_word;
          cmd_d   = {1'b0, OP_WRITE};
          cmd_w_d = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          text_d  = blk_word;
          cmd_d   = {1'b0, OP_WRITE};
          cmd_w_d = 1'b1;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'(BLK_WORDS - 1)) begin
            cnt_d   = 4'd0;
            state_d = ST_START;
          end
        end
      end
      ST_START: begin
        cmd_d    = {first_q, OP_START};
        cmd_w_d  = 1'b1;
        settle_d = 1'b1;
        state_d  = ST_WAIT;
`ifdef SHA_SEQ_TIMEOUT_EN
        to_cnt_d = '0;
`endif
      end
      ST_WAIT: begin
        // The first WAIT cycle carries the start strobe; busy has not risen yet.
        settle_d = 1'b0;
        if (!settle_q && !cmd_o[3]) begin
          idx_d   = 3'd0;
          rph_d   = 2'd0;
          state_d = ST_READ;
        end
`ifdef SHA_SEQ_TIMEOUT_EN
        else if (to_cnt_q >= TW'(BUSY_TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      ST_READ: begin
        case (rph_q)
          2'd0: begin
            text_d  = {29'd0, idx_q};
            cmd_d   = {1'b0, OP_READ};
            cmd_w_d = 1'b1;
            rph_d   = 2'd1;
          end
          2'd1: rph_d = 2'd2;
          default: begin
            dig_word_d = text_o;
            rph_d      = 2'd0;
            state_d    = ST_OUT;
          end
        endcase
      end
      ST_OUT: begin
        if (dig_ready) begin
          if (idx_q == 3'(DIG_WORDS - 1)) begin
            idx_d   = 3'd0;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_READ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      first_q    <= 1'b0;
      idx_q      <= 3'd0;
      rph_q      <= 2'd0;
      settle_q   <= 1'b0;
      rdy_en_q   <= 1'b0;
      text_q     <= 32'd0;
      cmd_q      <= 3'd0;
      cmd_w_q    <= 1'b0;
      dig_word_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
      idx_q      <= idx_d;
      rph_q      <= rph_d;
      settle_q   <= settle_d;
      rdy_en_q   <= rdy_en_d;
      text_q     <= text_d;
      cmd_q      <= cmd_d;
      cmd_w_q    <= cmd_w_d;
      dig_word_q <= dig_word_d;
    end
  end

`ifdef SHA_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q <= '0;
      error_q  <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      error_q  <= error_d;
    end
  end
`endif

endmodule

// File: tb/tb_sha_sequencer.sv
// Directed bench for sha_sequencer with a behavioural SHA-256 core model.
module tb_sha_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        blk_valid = 1'b0;
  logic [31:0] blk_word = 32'd0;
  logic        blk_first = 1'b0;
  logic        blk_ready;
  logic        dig_valid;
  logic [31:0] dig_word;
  logic        dig_last;
  logic        dig_ready = 1'b1;
  logic [31:0] text_i;
  logic [31:0] text_o;
  logic [2:0]  cmd_i;
  logic        cmd_w_i;
  logic [3:0]  cmd_o;
  logic        busy;
  logic        error;

  int checks = 0;
  int errors = 0;

  sha_sequencer dut (
    .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_word(blk_word),
    .blk_first(blk_first), .blk_ready(blk_ready), .dig_valid(dig_valid),
    .dig_word(dig_word), .dig_last(dig_last), .dig_ready(dig_ready),
    .text_i(text_i), .text_o(text_o), .cmd_i(cmd_i), .cmd_w_i(cmd_w_i),
    .cmd_o(cmd_o), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [31:0] ABC_H [8] = '{
    32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223, 32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
  localparam logic [31:0] TWO_H [8] = '{
    32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039, 32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};

  // Core model: registered read data, busy rises the edge after start.
  logic [31:0] wm [16];
  logic [31:0] hm [8];
  logic [3:0]  wptr;
  int          busy_cnt;
  bit          stuck = 1'b0;
  int          n_cmd = 0;
  int          n_wr = 0;

  assign cmd_o = {(stuck || busy_cnt != 0), 3'b000};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic compress(input bit first);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    if (first) for (int i = 0; i < 8; i++) hm[i] = IV[i];
    for (int t = 0; t < 16; t++) w[t] = wm[t];
    for (int t = 16; t < 64; t++)
      w[t] = w[t-16] + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3))
           + w[t-7] + (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10));
    a = hm[0]; b = hm[1]; c = hm[2]; d = hm[3]; e = hm[4]; f = hm[5]; g = hm[6]; h = hm[7];
    for (int t = 0; t < 64; t++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    hm[0] = hm[0] + a; hm[1] = hm[1] + b; hm[2] = hm[2] + c; hm[3] = hm[3] + d;
    hm[4] = hm[4] + e; hm[5] = hm[5] + f; hm[6] = hm[6] + g; hm[7] = hm[7] + h;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= 4'd0;
      busy_cnt <= 0;
      text_o   <= 32'd0;
    end else begin
      if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
      if (cmd_w_i) begin
        n_cmd <= n_cmd + 1;
        case (cmd_i[1:0])
          2'b10: begin wm[wptr] <= text_i; wptr <= wptr + 4'd1; n_wr <= n_wr + 1; end
          2'b11: begin compress(cmd_i[2]); wptr <= 4'd0; busy_cnt <= 12; end
          2'b01: text_o <= hm[text_i[2:0]];
          default: ;
        endcase
      end
    end
  end

  logic [31:0] msg [16];
  logic [31:0] exp_h [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) msg[i] = 32'd0;
    msg[0] = 32'h61626380; msg[15] = 32'h00000018;
    for (int i = 0; i < 8; i++) exp_h[i] = ABC_H[i];
  endtask

  task automatic set_two1();
    msg[0] = 32'h61626364; msg[1] = 32'h62636465; msg[2] = 32'h63646566; msg[3] = 32'h64656667;
    msg[4] = 32'h65666768; msg[5] = 32'h66676869; msg[6] = 32'h6768696a; msg[7] = 32'h68696a6b;
    msg[8] = 32'h696a6b6c; msg[9] = 32'h6a6b6c6d; msg[10] = 32'h6b6c6d6e; msg[11] = 32'h6c6d6e6f;
    msg[12] = 32'h6d6e6f70; msg[13] = 32'h6e6f7071; msg[14] = 32'h80000000; msg[15] = 32'h00000000;
  endtask

  task automatic set_two2();
    for (int i = 0; i < 16; i++) msg[i] = 32'd0;
    msg[15] = 32'h000001c0;
    for (int i = 0; i < 8; i++) exp_h[i] = TWO_H[i];
  endtask

  task automatic send(input bit first, input bit rnd, input int nwords);
    bit acc;
    int n;
    for (int i = 0; i < nwords; i++) begin
      acc = 1'b0;
      n = 0;
      while (!acc && n < 100) begin
        @(negedge clk);
        blk_word  = msg[i];
        blk_first = first;
        blk_valid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        acc = blk_valid && blk_ready;
        @(posedge clk);
        n++;
      end
      if (!acc) begin
        chk("blk_accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(negedge clk);
    blk_valid = 1'b0;
  endtask

  task automatic recv(input string tag, input bit chkval, input int stall_idx);
    int n;
    int cmd0;
    for (int j = 0; j < 8; j++) begin
      n = 0;
      @(negedge clk);
      while (!dig_valid && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (!dig_valid) begin
        chk({tag, "_dig_valid_timeout"}, 32'd0, 32'd1);
        return;
      end
      if (j == stall_idx) begin
        dig_ready = 1'b0;
        cmd0 = n_cmd;
        repeat (50) @(negedge clk);
        chk({tag, "_stall_word"}, dig_word, exp_h[j]);
        chk({tag, "_stall_valid"}, {31'd0, dig_valid}, 32'd1);
        chk({tag, "_stall_no_cmd"}, n_cmd, cmd0);
        dig_ready = 1'b1;
      end
      if (chkval) chk({tag, "_dig_word"}, dig_word, exp_h[j]);
      chk({tag, "_dig_last"}, {31'd0, dig_last}, {31'd0, (j == 7)});
      @(posedge clk);
    end
    @(negedge clk);
    chk({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int wr0;
    bit saw_valid;
    repeat (2) @(negedge clk);
    chk("rst_blk_ready", {31'd0, blk_ready}, 32'd0);
    chk("rst_dig_valid", {31'd0, dig_valid}, 32'd0);
    chk("rst_dig_last", {31'd0, dig_last}, 32'd0);
    chk("rst_dig_word", dig_word, 32'd0);
    chk("rst_text_i", text_i, 32'd0);
    chk("rst_cmd", {28'd0, cmd_i, cmd_w_i}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready_low", {31'd0, blk_ready}, 32'd0);
    @(negedge clk);
    chk("post_rst_ready_high", {31'd0, blk_ready}, 32'd1);

    // Single "abc" block
    set_abc();
    wr0 = n_wr;
    send(1'b1, 1'b0, 16);
    recv("abc", 1'b1, -1);
    chk("abc_writes", n_wr - wr0, 32'd16);

    // Two-block message chained with blk_first=0 on the second block
    set_two1();
    send(1'b1, 1'b0, 16);
    recv("two_blk1", 1'b0, -1);
    set_two2();
    send(1'b0, 1'b0, 16);
    recv("two_blk2", 1'b1, -1);

    // Random gaps in blk_valid
    set_abc();
    wr0 = n_wr;
    send(1'b1, 1'b1, 16);
    recv("rnd", 1'b1, -1);
    chk("rnd_writes", n_wr - wr0, 32'd16);

    // Consumer stall on H3
    set_abc();
    send(1'b1, 1'b0, 16);
    recv("stall", 1'b1, 3);

    // Reset after W9, then a clean block
    set_abc();
    send(1'b1, 1'b0, 10);
    rst = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_ready", {31'd0, blk_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    wr0 = n_wr;
    send(1'b1, 1'b0, 16);
    recv("after_rst", 1'b1, -1);
    chk("after_rst_writes", n_wr - wr0, 32'd16);

`ifdef SHA_SEQ_TIMEOUT_EN
    // Core busy stuck high: watchdog must abort without a digest
    stuck = 1'b1;
    set_abc();
    send(1'b1, 1'b0, 16);
    saw_valid = 1'b0;
    for (int c = 0; c < 1100; c++) begin
      @(negedge clk);
      if (dig_valid) saw_valid = 1'b1;
    end
    chk("to_error", {31'd0, error}, 32'd1);
    chk("to_idle", {31'd0, busy}, 32'd0);
    chk("to_no_digest", {31'd0, saw_valid}, 32'd0);
    stuck = 1'b0;
`else
    saw_valid = 1'b0;
    chk("error_tied_low", {31'd0, error}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha_sequencer.md
SHA_SEQUENCER -- requirements
Module: sha_sequencer

Interface
REQ-001 Parameter BUSY_TIMEOUT, default 1024: maximum cycles WAIT_DONE waits for core busy to clear (used only with SHA_SEQ_TIMEOUT_EN).
REQ-002 clk  input  1  master clock; all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 blk_valid  input  1  requester offers a message word.
REQ-005 blk_word  input  32  message word, big-endian word order W0..W15.
REQ-006 blk_first  input  1  sampled with W0; 1 = new message (core IV reload), 0 = continue chaining.
REQ-007 blk_ready  output  1  sequencer accepts blk_word this cycle.
REQ-008 dig_valid  output  1  digest word available.
REQ-009 dig_word  output  32  digest word H0..H7.
REQ-010 dig_last  output  1  marks H7.
REQ-011 dig_ready  input  1  consumer accepts dig_word.
REQ-012 text_i  output  32  word to sha256 core.
REQ-013 text_o  input  32  word from sha256 core.
REQ-014 cmd_i  output  3  core command: [2] first flag, [1:0] op (01 read, 10 write, 11 start).
REQ-015 cmd_w_i  output  1  one-cycle command strobe to core.
REQ-016 cmd_o  input  4  core status; [3] = busy.
REQ-017 busy  output  1  high in any state except IDLE.
REQ-018 error  output  1  sticky timeout flag (SHA_SEQ_TIMEOUT_EN only; else tied 0).

Function
REQ-019 States: IDLE, LOAD, START, WAIT_DONE, READ, OUT.
REQ-020 IDLE: blk_ready=1; on blk_valid&blk_ready, go LOAD with word count 1, latch blk_first, issue write of W0.
REQ-021 Each accepted word issues cmd_w_i=1, cmd_i op=10, text_i=blk_word in the cycle after acceptance (1-cycle latency).
REQ-022 LOAD: blk_ready=1 while count<16; count 4 bits, after W15 accepted go START; no word accepted beyond 16.
REQ-023 START: one cycle, cmd_w_i=1, op=11, cmd_i[2]=latched first flag; next WAIT_DONE.
REQ-024 WAIT_DONE: ignore cmd_o[3] in first cycle (core busy-rise latency); thereafter on cmd_o[3]=0 go READ with index 0.
REQ-025 READ: issue read strobe (op=01) for index n; capture text_o exactly one cycle later into dig_word; go OUT.
REQ-026 OUT: dig_valid=1 holding dig_word stable until dig_ready; dig_last=1 when index=7; on handshake index+1 and READ, or IDLE after index 7.
REQ-027 dig_ready low stalls OUT indefinitely with no further core commands.
REQ-028 blk_valid outside IDLE/LOAD is ignored (blk_ready=0); requester holds word.
REQ-029 cmd_w_i never high two consecutive cycles except during back-to-back LOAD writes.
REQ-030 Every digest is 8 words, never truncated.

Reset
REQ-031 rst asserted at any time, including mid-LOAD or mid-OUT, forces IDLE within the same edge; partial block discarded.
REQ-032 Reset values: blk_ready=0 until first clk after rst deasserts, then 1; dig_valid=0, dig_last=0, dig_word=0, text_i=0, cmd_i=0, cmd_w_i=0, busy=0, error=0, counters 0.

Configuration
REQ-033 Macro SHA_SEQ_TIMEOUT_EN defined: WAIT_DONE counter; if busy persists BUSY_TIMEOUT cycles, set error, go IDLE, no digest emitted; error cleared only by rst.
REQ-034 Macro undefined: no counter, WAIT_DONE waits indefinitely, error constant 0.

Structure
REQ-035 Shared package sha_pkg holds state encoding, cmd op constants (READ/WRITE/START), word counts 16 and 8.
REQ-036 Single module, no sub-modules; core instantiated by parent alongside uart and input_handler.

Verification
REQ-037 "abc" padded block, blk_first=1, dig_ready=1 -> 8 words ba7816bf,8f01cfea,414140de,5dae2223,b00361a3,96177a9c,b410ff61,f20015ad; dig_last on last.
REQ-038 Two-block 56-char "abcdbcdecdef...nopq" message, second block blk_first=0 -> digest beginning 248d6a61, ending 19db06c1.
REQ-039 blk_valid toggled randomly during LOAD -> exactly 16 writes, same digest as REQ-037.
REQ-040 dig_ready low 50 cycles on H3 -> dig_word held at 5dae2223, no core command issued meanwhile.
REQ-041 rst pulsed after W9 accepted, then full "abc" block -> correct digest, no stale words.
REQ-042 SHA_SEQ_TIMEOUT_EN, model busy stuck high -> error=1 after 1024 cycles, IDLE, dig_valid never asserted.
